// File: rtl/dmem_bus.sv
// Data memory for the MIPS-31 load/store unit: word, half and byte access,
// programmable wait states, and error reporting on a single-cycle ready pulse.
module dmem_bus #(
  parameter int unsigned DEPTH     = 2048,
  parameter logic [31:0] BASE_ADDR = 32'h1001_0000,
  parameter int unsigned LATENCY   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [2:0]  mode,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err,
  output logic        busy
);

  localparam int unsigned IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [2:0]  CNT_INIT = (LATENCY > 0) ? 3'(LATENCY - 1) : 3'd0;

  localparam logic [2:0] MODE_W  = 3'd0;
  localparam logic [2:0] MODE_HS = 3'd1;
  localparam logic [2:0] MODE_HU = 3'd2;
  localparam logic [2:0] MODE_BS = 3'd3;
  localparam logic [2:0] MODE_BU = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DONE
  } state_e;

  state_e      state_q;
  logic [2:0]  cnt_q;
  logic        we_q;
  logic [2:0]  mode_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        ready_q;
  logic        err_q;
  logic        busy_q;
  logic [31:0] mem_q [DEPTH];

  logic             acc_we_c;
  logic [2:0]       acc_mode_c;
  logic [31:0]      acc_addr_c;
  logic [31:0]      acc_wdata_c;
  logic [31:0]      off_c;
  logic [IDX_W-1:0] idx_c;
  logic             is_word_c;
  logic             is_half_c;
  logic             enter_done_c;
  logic             mem_we_c;
  logic             err_d;
  logic [31:0]      rd_word_c;
  logic [15:0]      half_c;
  logic [7:0]       byte_c;
  logic [31:0]      load_c;
  logic [31:0]      wr_word_c;
  logic [31:0]      rdata_d;

  // With zero wait states the request completes on its acceptance edge,
  // so the access is evaluated on the live inputs while idle.
  always_comb begin
    if (state_q == ST_IDLE) begin
      acc_we_c    = we;
      acc_mode_c  = mode;
      acc_addr_c  = addr;
      acc_wdata_c = wdata;
    end else begin
      acc_we_c    = we_q;
      acc_mode_c  = mode_q;
      acc_addr_c  = addr_q;
      acc_wdata_c = wdata_q;
    end
  end

  always_comb begin
    enter_done_c = 1'b0;
    if (state_q == ST_IDLE) begin
      enter_done_c = req && (LATENCY == 0);
    end else if (state_q == ST_WAIT) begin
      enter_done_c = (cnt_q == 3'd0);
    end
  end

  // Address decode and error classification
  always_comb begin
    off_c     = acc_addr_c - BASE_ADDR;
    idx_c     = off_c[IDX_W+1:2];
    is_word_c = (acc_mode_c == MODE_W);
    is_half_c = (acc_mode_c == MODE_HS) || (acc_mode_c == MODE_HU);
    err_d     = (acc_mode_c > MODE_BU)
             || (acc_addr_c < BASE_ADDR)
             || (off_c[31:2] >= 30'(DEPTH))
             || (is_word_c && (off_c[1:0] != 2'd0))
             || (is_half_c && off_c[0]);
  end

  // Lane selection and extension for loads
  always_comb begin
    rd_word_c = mem_q[idx_c];
    half_c    = rd_word_c[{off_c[1], 4'b0000} +: 16];
    byte_c    = rd_word_c[{off_c[1:0], 3'b000} +: 8];
    case (acc_mode_c)
      MODE_W:  load_c = rd_word_c;
      MODE_HS: load_c = {{16{half_c[15]}}, half_c};
      MODE_HU: load_c = {16'h0000, half_c};
      MODE_BS: load_c = {{24{byte_c[7]}}, byte_c};
      MODE_BU: load_c = {24'h00_0000, byte_c};
      default: load_c = 32'h0000_0000;
    endcase
    if (err_d) begin
      rdata_d = 32'h0000_0000;
    end else if (acc_we_c) begin
      rdata_d = rdata_q;
    end else begin
      rdata_d = load_c;
    end
  end

  // Lane merge for stores; unselected lanes keep their old contents
  always_comb begin
    wr_word_c = rd_word_c;
    case (acc_mode_c)
      MODE_W:           wr_word_c = acc_wdata_c;
      MODE_HS, MODE_HU: wr_word_c[{off_c[1], 4'b0000} +: 16] = acc_wdata_c[15:0];
      MODE_BS, MODE_BU: wr_word_c[{off_c[1:0], 3'b000} +: 8] = acc_wdata_c[7:0];
      default:          wr_word_c = rd_word_c;
    endcase
    mem_we_c = enter_done_c && acc_we_c && !err_d && !rst;
  end

  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      mem_q[idx_c] <= wr_word_c;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 3'd0;
      we_q    <= 1'b0;
      mode_q  <= 3'd0;
      addr_q  <= 32'h0000_0000;
      wdata_q <= 32'h0000_0000;
      rdata_q <= 32'h0000_0000;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req) begin
            we_q    <= we;
            mode_q  <= mode;
            addr_q  <= addr;
            wdata_q <= wdata;
            busy_q  <= 1'b1;
            cnt_q   <= CNT_INIT;
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt_q != 3'd0) begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          err_q   <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
      // Completion overrides the WAIT hand-off above
      if (enter_done_c) begin
        state_q <= ST_DONE;
        ready_q <= 1'b1;
        err_q   <= err_d;
        rdata_q <= rdata_d;
      end
    end
  end

  assign rdata = rdata_q;
  assign ready = ready_q;
  assign err   = err_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_dmem_bus.sv
// Scoreboard bench for dmem_bus: directed accesses on a LATENCY=2 instance,
// plus a zero-wait-state instance for the short handshake.
module tb_dmem_bus;

  logic        clk;
  logic        rst;
  logic        req, we;
  logic [2:0]  mode;
  logic [31:0] addr, wdata, rdata;
  logic        ready, err, busy;
  logic        req0, we0;
  logic [2:0]  mode0;
  logic [31:0] addr0, wdata0, rdata0;
  logic        ready0, err0, busy0;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [31:0] rd;
    logic        er;
    int          acc;
  } exp_t;

  exp_t sb_q[$];

  dmem_bus #(.DEPTH(2048), .BASE_ADDR(32'h1001_0000), .LATENCY(2)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .mode(mode), .addr(addr),
    .wdata(wdata), .rdata(rdata), .ready(ready), .err(err), .busy(busy)
  );

  dmem_bus #(.DEPTH(2048), .BASE_ADDR(32'h1001_0000), .LATENCY(0)) dut0 (
    .clk(clk), .rst(rst), .req(req0), .we(we0), .mode(mode0), .addr(addr0),
    .wdata(wdata0), .rdata(rdata0), .ready(ready0), .err(err0), .busy(busy0)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp_v);
    end
  endfunction

  // Monitor: every ready pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (!rst && ready) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_ready", 32'(ready), 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("rdata", rdata, e.rd);
        chk("err", 32'(err), 32'(e.er));
        chk("latency", 32'(cyc - e.acc), 32'd3);
      end
    end
  end

  task automatic issue(input logic w, input logic [2:0] m, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_er);
    exp_t e;
    @(negedge clk);
    req = 1'b1; we = w; mode = m; addr = a; wdata = wd;
    e.rd = exp_rd; e.er = exp_er; e.acc = cyc;
    sb_q.push_back(e);
    @(negedge clk);
    req = 1'b0;
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge clk);
    if (sb_q.size() != 0) begin
      chk("ready_timeout", 32'(sb_q.size()), 32'd0);
      sb_q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int busy_n;
    rst = 1'b1;
    req = 1'b0; we = 1'b0; mode = 3'd0; addr = 32'h0; wdata = 32'h0;
    req0 = 1'b0; we0 = 1'b0; mode0 = 3'd0; addr0 = 32'h0; wdata0 = 32'h0;
    #2;
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Word, byte and halfword stores/loads
    issue(1'b1, 3'd0, 32'h1001_0004, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0);
    issue(1'b0, 3'd0, 32'h1001_0004, 32'h0,         32'hDEAD_BEEF, 1'b0);
    issue(1'b1, 3'd3, 32'h1001_0005, 32'h0000_00A5, 32'hDEAD_BEEF, 1'b0);
    issue(1'b0, 3'd0, 32'h1001_0004, 32'h0,         32'hDEAD_A5EF, 1'b0);
    issue(1'b0, 3'd3, 32'h1001_0005, 32'h0,         32'hFFFF_FFA5, 1'b0);
    issue(1'b0, 3'd4, 32'h1001_0005, 32'h0,         32'h0000_00A5, 1'b0);
    issue(1'b1, 3'd1, 32'h1001_0006, 32'h0000_1234, 32'h0000_00A5, 1'b0);
    issue(1'b0, 3'd0, 32'h1001_0004, 32'h0,         32'h1234_A5EF, 1'b0);
    issue(1'b0, 3'd1, 32'h1001_0006, 32'h0,         32'h0000_1234, 1'b0);
    issue(1'b0, 3'd1, 32'h1001_0004, 32'h0,         32'hFFFF_A5EF, 1'b0);
    issue(1'b0, 3'd2, 32'h1001_0004, 32'h0,         32'h0000_A5EF, 1'b0);
    issue(1'b0, 3'd3, 32'h1001_0007, 32'h0,         32'h0000_0012, 1'b0);

    // Last word in range
    issue(1'b1, 3'd0, 32'h1001_1FFC, 32'hCAFE_F00D, 32'h0000_0012, 1'b0);
    issue(1'b0, 3'd0, 32'h1001_1FFC, 32'h0,         32'hCAFE_F00D, 1'b0);

    // Error cases, each followed by a word read-back of 0x10010004
    issue(1'b0, 3'd0, 32'h1001_0002, 32'h0,         32'h0000_0000, 1'b1);
    issue(1'b0, 3'd0, 32'h1001_0004, 32'h0,         32'h1234_A5EF, 1'b0);
    issue(1'b0, 3'd1, 32'h1001_0005, 32'h0,         32'h0000_0000, 1'b1);
    issue(1'b1, 3'd0, 32'h1000_FFFC, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
    issue(1'b0, 3'd0, 32'h1001_2000, 32'h0,         32'h0000_0000, 1'b1);
    issue(1'b1, 3'd7, 32'h1001_0004, 32'h0000_0000, 32'h0000_0000, 1'b1);
    issue(1'b1, 3'd0, 32'h1001_0006, 32'h0000_0000, 32'h0000_0000, 1'b1);
    issue(1'b1, 3'd1, 32'h1001_0005, 32'h0000_0000, 32'h0000_0000, 1'b1);
    issue(1'b0, 3'd0, 32'h1001_0004, 32'h0,         32'h1234_A5EF, 1'b0);

    // Reset abort during WAIT
    issue(1'b1, 3'd0, 32'h1001_0008, 32'h55AA_55AA, 32'h1234_A5EF, 1'b0);
    @(negedge clk);
    req = 1'b1; we = 1'b1; mode = 3'd0; addr = 32'h1001_0008; wdata = 32'h1111_1111;
    @(negedge clk);
    req = 1'b0;
    chk("abort_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_ready", 32'(ready), 32'd0);
    chk("abort_err", 32'(err), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_rdata", rdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    issue(1'b0, 3'd0, 32'h1001_0008, 32'h0, 32'h55AA_55AA, 1'b0);

    // Continuous request: one ready every 4 cycles, busy 3 of 4
    @(negedge clk);
    k = cyc;
    req = 1'b1; we = 1'b0; mode = 3'd0; addr = 32'h1001_0004; wdata = 32'h0;
    for (int i = 0; i < 4; i++) begin
      exp_t e;
      e.rd = 32'h1234_A5EF; e.er = 1'b0; e.acc = k + 4 * i;
      sb_q.push_back(e);
    end
    busy_n = 0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (busy) busy_n++;
    end
    req = 1'b0;
    chk("hold_busy_cycles", 32'(busy_n), 32'd12);
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge clk);
    chk("hold_ready_count", 32'(sb_q.size()), 32'd0);
    sb_q.delete();

    // Zero wait states: ready the cycle after acceptance, interval 2
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b1; mode0 = 3'd0; addr0 = 32'h1001_0000; wdata0 = 32'h0BAD_F00D;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      chk("l0_ready", 32'(ready0), (i % 2 == 1) ? 32'd1 : 32'd0);
      chk("l0_busy", 32'(busy0), (i % 2 == 1) ? 32'd1 : 32'd0);
    end
    req0 = 1'b0;
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b0;
    @(negedge clk);
    req0 = 1'b0;
    chk("l0_load_ready", 32'(ready0), 32'd1);
    chk("l0_load_rdata", rdata0, 32'h0BAD_F00D);
    chk("l0_load_err", 32'(err0), 32'd0);

    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_bus.md
Name: dmem_bus

Overview:
- Parametrised data memory for the MIPS-31 CPU, replacing the fixed word-only DRAM.
- Adds byte and halfword loads and stores with sign or zero extension.
- Adds a programmable wait-state request/ready handshake, plus error detection for misaligned, out-of-range and illegal-mode accesses.
- Sits between the CPU datapath (load/store unit) and on-chip storage. The CPU stalls while busy is high.

Parameters:
- DEPTH, 2048: number of 32-bit words. Must be a power of 2.
- BASE_ADDR, 32'h10010000: byte address of word 0. Must be 4-aligned.
- LATENCY, 1: wait cycles inserted before the response. Legal range 0..7.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  1  access request; sampled only in IDLE.
- we  in  1  1 = store, 0 = load.
- mode  in  3  000 word, 001 half signed, 010 half unsigned, 011 byte signed, 100 byte unsigned; all other codes illegal.
- addr  in  32  byte address.
- wdata  in  32  store data, taken from the low bits (sh uses [15:0], sb uses [7:0]).
- rdata  out  32  load result, extended to 32 bits.
- ready  out  1  one-cycle completion pulse.
- err  out  1  error flag; valid only with ready.
- busy  out  1  high from the cycle after acceptance through the ready cycle.

Behaviour:
- Reset (async, immediate): state = IDLE; ready = 0, err = 0, busy = 0, rdata = 0; wait counter = 0. Memory contents are not cleared.
- FSM states: IDLE, WAIT, DONE.
  - IDLE: if req = 1 at an edge, latch we, mode, addr and wdata. Go to WAIT (LATENCY > 0, counter loaded with LATENCY-1) or DONE (LATENCY = 0).
  - WAIT: counter decrements each cycle; at 0, go to DONE.
  - DONE: ready = 1 for exactly this cycle, then go to IDLE unconditionally.
- Timing:
  - Acceptance edge = cycle 0; ready is high in cycle LATENCY+1.
  - Minimum issue interval is LATENCY+2 cycles.
  - req while busy is ignored; it is not queued.
- Error checks, evaluated on the latched request:
  - mode code is illegal;
  - addr < BASE_ADDR;
  - (addr - BASE_ADDR) >> 2 >= DEPTH;
  - word access with addr[1:0] != 0;
  - half access with addr[0] != 0.
  - On any error: err = 1 with ready, no memory write, rdata = 0.
- Word index: (addr - BASE_ADDR) >> 2, truncated to log2(DEPTH) bits after the range check passes.
- Byte lanes are little-endian: byte 0 = bits [7:0].
  - sh writes lane pair addr[1] (0 → bits [15:0], 1 → bits [31:16]).
  - sb writes byte addr[1:0].
  - Unselected lanes are preserved.
- Stores: memory is written on the edge that enters DONE. rdata is unchanged by a store.
- Loads: rdata is registered on the edge that enters DONE and holds until the next completed load or reset.
  - lh/lb sign-extend from bit 15/7 of the selected lane.
  - lhu/lbu zero-extend.
- Reset mid-operation: the pending access is aborted, no memory write occurs, and no ready is issued.
- Memory is inferred as a register array with a synchronous write. The read mux reads the latched index combinationally.

Test Plan (DEPTH = 2048, BASE_ADDR = 0x10010000, LATENCY = 2 unless stated):
- Word store/load: sw 0x10010004 wdata 0xDEADBEEF, then lw 0x10010004 → ready in cycle 3 after each acceptance, rdata = 0xDEADBEEF, err = 0.
- Byte store and loads: sb 0x10010005 wdata 0x000000A5.
  - lw → 0xDEADA5EF
  - lb 0x10010005 → 0xFFFFFFA5
  - lbu → 0x000000A5
- Halfword store and loads: sh 0x10010006 wdata 0x00001234, then lw 0x10010004 → 0x1234A5EF.
  - lh 0x10010006 → 0x00001234
  - lh 0x10010004 → 0xFFFFA5EF
  - lhu 0x10010004 → 0x0000A5EF
- Errors: each of the following gives ready = 1, err = 1, rdata = 0, and memory unchanged (verified by a following lw):
  - lw 0x10010002
  - lh 0x10010005
  - sw 0x1000FFFC
  - lw 0x10012000
  - mode 111
- Handshake: hold req = 1 continuously → exactly one ready every 4 cycles and busy high for 3 of every 4. With LATENCY = 0: ready the cycle after acceptance, issue interval 2.
- Reset abort: sw 0x10010008 wdata 0x11111111, then assert rst in cycle 1 (during WAIT) → ready, err, busy and rdata go to 0 immediately. A later lw 0x10010008 returns the prior contents, not 0x11111111.
